sync_level_fifo: RTL and testbench

Single-clock, parametrised successor to the dual-clock block FIFO. It is used where producer and consumer share one clock, such as SPI byte staging and sample buffering ahead of the packetiser. It adds an exact fill-level count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow flags, a synchronous flush, and a selectable read mode (first-word-fall-through or registered read).

---
 rtl/sync_level_fifo.sv | 97 +++++++++
 tb/tb_sync_level_fifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sync_level_fifo.sv
// sync_level_fifo: single-clock FIFO with fill level, thresholds, sticky error flags, flush and selectable read mode
module sync_level_fifo #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 4,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 4,
    parameter int FWFT       = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE-1:0] r_waddr, r_raddr;
    logic [ASIZE:0]   r_count;
    logic             r_overflow, r_underflow;
    logic             w_wacc, w_racc;

    // flags come only from the registered count, so no request-to-flag path exists
    assign wfull         = r_count == (ASIZE+1)'(DEPTH);
    assign rempty        = r_count == '0;
    assign walmost_full  = r_count >= (ASIZE+1)'(AFULL_LVL);
    assign ralmost_empty = r_count <= (ASIZE+1)'(AEMPTY_LVL);
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    // flush blocks both accepts so nothing moves while clearing
    assign w_wacc = winc & ~wfull & ~flush;
    assign w_racc = rinc & ~rempty & ~flush;

    // pointers, fill level and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wacc) r_waddr <= r_waddr + 1'b1;
            if (w_racc) r_raddr <= r_raddr + 1'b1;
            r_count <= r_count + (ASIZE+1)'(w_wacc) - (ASIZE+1)'(w_racc);
            if (winc & wfull)  r_overflow  <= 1'b1;
            if (rinc & rempty) r_underflow <= 1'b1;
        end
    end

    // storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (w_wacc) r_mem[r_waddr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = r_mem[r_raddr];
            assign rvalid = ~rempty;
        end else begin : g_reg
            logic [DSIZE-1:0] r_rdata;
            logic             r_rvalid;
            // registered read: one-cycle latency, data held between reads
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (flush) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_racc;
                    if (w_racc) r_rdata <= r_mem[r_raddr];
                end
            end
            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end
    endgenerate
endmodule

// File: tb/tb_sync_level_fifo.sv
// tb_sync_level_fifo: scoreboard bench for FWFT and registered-read builds
module tb_sync_level_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, winc = 1'b0, rinc = 1'b0;
    logic [7:0] wdata = '0;
    logic       wfull, walmost_full, rvalid, rempty, ralmost_empty, overflow, underflow;
    logic [7:0] rdata;
    logic [4:0] count;
    logic       b_flush = 1'b0, b_winc = 1'b0, b_rinc = 1'b0;
    logic [7:0] b_wdata = '0;
    logic       b_wfull, b_walmost_full, b_rvalid, b_rempty, b_ralmost_empty, b_overflow, b_underflow;
    logic [7:0] b_rdata;
    logic [4:0] b_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] q[$];
    logic [7:0] qb[$];
    bit m_ov = 0, m_un = 0;
    logic [7:0] b_last = 8'h00;

    always #5 clk = ~clk;

    sync_level_fifo #(.FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wdata(wdata), .winc(winc),
        .wfull(wfull), .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata),
        .rvalid(rvalid), .rempty(rempty), .ralmost_empty(ralmost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_level_fifo #(.FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .wdata(b_wdata), .winc(b_winc),
        .wfull(b_wfull), .walmost_full(b_walmost_full), .rinc(b_rinc), .rdata(b_rdata),
        .rvalid(b_rvalid), .rempty(b_rempty), .ralmost_empty(b_ralmost_empty),
        .count(b_count), .overflow(b_overflow), .underflow(b_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic status();
        check("count", 32'(count), 32'(q.size()));
        check("wfull", 32'(wfull), 32'(q.size() == 16));
        check("walmost_full", 32'(walmost_full), 32'(q.size() >= 12));
        check("rempty", 32'(rempty), 32'(q.size() == 0));
        check("ralmost_empty", 32'(ralmost_empty), 32'(q.size() <= 4));
        check("rvalid", 32'(rvalid), 32'(q.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ov));
        check("underflow", 32'(underflow), 32'(m_un));
    endtask

    task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f);
        bit full, empty;
        winc = w; wdata = d; rinc = r; flush = f;
        full = q.size() == 16;
        empty = q.size() == 0;
        if (f) begin
            q.delete(); m_ov = 0; m_un = 0;
        end else begin
            if (w && full) m_ov = 1;
            if (r && empty) m_un = 1;
            if (r && !empty) begin
                check("rdata_head", 32'(rdata), 32'(q[0]));
                void'(q.pop_front());
            end
            if (w && !full) q.push_back(d);
        end
        @(posedge clk); #1;
        winc = 0; rinc = 0; flush = 0;
        status();
    endtask

    task automatic bcyc(input bit w, input logic [7:0] d, input bit r);
        bit exp_v;
        b_winc = w; b_wdata = d; b_rinc = r;
        exp_v = r && qb.size() != 0;
        if (exp_v) b_last = qb.pop_front();
        if (w && qb.size() < 16) qb.push_back(d);
        @(posedge clk); #1;
        b_winc = 0; b_rinc = 0;
        check("b_rvalid", 32'(b_rvalid), 32'(exp_v));
        check("b_rdata", 32'(b_rdata), 32'(b_last));
        check("b_count", 32'(b_count), 32'(qb.size()));
        check("b_rempty", 32'(b_rempty), 32'(qb.size() == 0));
    endtask

    task automatic fill_to_nine_with_overflow();
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0);
        cyc(1, 8'hEE, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
    endtask

    initial begin
        int written;
        bit up;
        #2;
        status();
        check("b_rvalid_rst", 32'(b_rvalid), 32'd0);
        check("b_rdata_rst", 32'(b_rdata), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'hAA, 0, 0);
        cyc(1, 8'hBB, 1, 0);
        while (q.size() != 0) cyc(0, 0, 1, 0);
        cyc(1, 8'hCC, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        written = 0;
        up = 1;
        for (int k = 0; k < 200 && written < 40; k++) begin
            if (q.size() >= 7) up = 0;
            else if (q.size() <= 3) up = 1;
            if (up || q.size() > 3 && k % 3 == 0) begin
                cyc(1, 8'(8'h80 + written), !up || k % 2 == 1, 0);
                written++;
            end else begin
                cyc(0, 0, 1, 0);
            end
        end
        check("wrap_written", 32'(written), 32'd40);
        while (q.size() != 0) cyc(0, 0, 1, 0);
        fill_to_nine_with_overflow();
        cyc(1, 8'h77, 0, 1);
        cyc(1, 8'h33, 0, 0);
        cyc(0, 0, 1, 0);
        fill_to_nine_with_overflow();
        #2 rst_n = 1'b0;
        q.delete(); m_ov = 0; m_un = 0;
        #1 status();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 8'h5C, 0, 0);
        cyc(0, 0, 1, 0);
        bcyc(1, 8'h5A, 0);
        bcyc(0, 0, 1);
        bcyc(0, 0, 0);
        for (int i = 0; i < 3; i++) bcyc(1, 8'(8'hA0 + i), 0);
        for (int i = 0; i < 4; i++) bcyc(0, 0, 1);
        bcyc(0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
